// File: rtl/atahost_pio_arbiter.sv
// Two-port round-robin arbiter in front of the ATA PIO timing controller.
// It supports an optional ownership lock and a watchdog for PIO cycles that are never acknowledged.
module atahost_pio_arbiter #(
    parameter int unsigned   CW    = 12,
    parameter logic [CW-1:0] TOUT  = CW'(4095),
    parameter logic [CW-1:0] LTOUT = CW'(255)
) (
    input  logic        wb_clk_i,
    input  logic        arst_signal,
    input  logic        rst,

    input  logic        req0,
    input  logic        we0,
    input  logic [3:0]  adr0,
    input  logic [15:0] dat0,
    input  logic        lock0,
    output logic        ack0,
    output logic        err0,
    output logic [15:0] q0,

    input  logic        req1,
    input  logic        we1,
    input  logic [3:0]  adr1,
    input  logic [15:0] dat1,
    input  logic        lock1,
    output logic        ack1,
    output logic        err1,
    output logic [15:0] q1,

    output logic        PIOreq,
    output logic        PIOwe,
    output logic [3:0]  PIOa,
    output logic [15:0] PIOd,
    input  logic        PIOack,
    input  logic [15:0] PIOq,

    output logic        busy,
    output logic        owner
);

    localparam logic [CW-1:0] TOUT_M1  = TOUT - CW'(1);
    localparam logic [CW-1:0] LTOUT_M1 = LTOUT - CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2,
        S_LOCK = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_grant;
    logic          r_last;
    logic [CW-1:0] r_cnt;

    logic          w_in_busy;
    logic          w_req_g;
    logic          w_lock_g;
    logic          w_win;
    logic          w_tout;
    logic          w_ltout;
    logic          w_ack;
    logic          w_err;
    logic [CW-1:0] w_cnt_inc;

    assign w_in_busy = (r_state == S_BUSY);
    assign w_req_g   = r_grant ? req1  : req0;
    assign w_lock_g  = r_grant ? lock1 : lock0;

    // When both ports request, the port that was not served last wins.
    assign w_win     = (req0 & req1) ? ~r_last : req1;

    assign w_tout    = (TOUT  != '0) && (r_cnt == TOUT_M1);
    assign w_ltout   = (LTOUT != '0) && (r_cnt == LTOUT_M1);
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);

    // If the ack and the timeout occur in the same cycle, the ack takes priority.
    assign w_ack     = w_in_busy & PIOack;
    assign w_err     = w_in_busy & ~PIOack & w_tout;

    assign ack0      = w_ack & ~r_grant;
    assign ack1      = w_ack &  r_grant;
    assign err0      = w_err & ~r_grant;
    assign err1      = w_err &  r_grant;
    assign q0        = PIOq;
    assign q1        = PIOq;

    // The PIO mux is forced to zero outside BUSY so the controller sees a quiet bus.
    assign PIOreq    = w_in_busy;
    assign PIOwe     = w_in_busy & (r_grant ? we1 : we0);
    assign PIOa      = w_in_busy ? (r_grant ? adr1 : adr0) : 4'h0;
    assign PIOd      = w_in_busy ? (r_grant ? dat1 : dat0) : 16'h0000;

    assign busy      = (r_state != S_IDLE);
    assign owner     = r_grant;

    // Arbitration, lock and watchdog state machine.
    always_ff @(posedge wb_clk_i or negedge arst_signal) begin
        if (!arst_signal) begin
            r_state <= S_IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else if (rst) begin
            r_state <= S_IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req0 | req1) begin
                        r_grant <= w_win;
                        r_cnt   <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_cnt <= w_cnt_inc;
                    if (PIOack || w_tout) begin
                        r_last  <= r_grant;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_cnt   <= '0;
                    r_state <= w_lock_g ? S_LOCK : S_IDLE;
                end
                S_LOCK: begin
                    if (w_req_g) begin
                        r_cnt   <= '0;
                        r_state <= S_BUSY;
                    end else if (!w_lock_g || w_ltout) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atahost_pio_arbiter.sv
// Directed bench for atahost_pio_arbiter.
// dut uses TOUT=16/LTOUT=8; dut_def keeps the default parameters for the long-ack access.
module tb_atahost_pio_arbiter;

    logic        clk = 1'b0;
    logic        arst_signal;
    logic        rst;
    logic        req0, we0, lock0, req1, we1, lock1;
    logic [3:0]  adr0, adr1;
    logic [15:0] dat0, dat1;
    logic        PIOack;
    logic [15:0] PIOq;

    logic        ack0, err0, ack1, err1, PIOreq, PIOwe, busy, owner;
    logic [15:0] q0, q1, PIOd;
    logic [3:0]  PIOa;

    logic        d_ack0, d_err0, d_ack1, d_err1, d_PIOreq, d_PIOwe, d_busy, d_owner;
    logic [15:0] d_q0, d_q1, d_PIOd;
    logic [3:0]  d_PIOa;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    atahost_pio_arbiter #(.CW(12), .TOUT(12'd16), .LTOUT(12'd8)) dut (
        .wb_clk_i(clk), .arst_signal(arst_signal), .rst(rst),
        .req0(req0), .we0(we0), .adr0(adr0), .dat0(dat0), .lock0(lock0),
        .ack0(ack0), .err0(err0), .q0(q0),
        .req1(req1), .we1(we1), .adr1(adr1), .dat1(dat1), .lock1(lock1),
        .ack1(ack1), .err1(err1), .q1(q1),
        .PIOreq(PIOreq), .PIOwe(PIOwe), .PIOa(PIOa), .PIOd(PIOd),
        .PIOack(PIOack), .PIOq(PIOq), .busy(busy), .owner(owner)
    );

    atahost_pio_arbiter dut_def (
        .wb_clk_i(clk), .arst_signal(arst_signal), .rst(rst),
        .req0(req0), .we0(we0), .adr0(adr0), .dat0(dat0), .lock0(lock0),
        .ack0(d_ack0), .err0(d_err0), .q0(d_q0),
        .req1(req1), .we1(we1), .adr1(adr1), .dat1(dat1), .lock1(lock1),
        .ack1(d_ack1), .err1(d_err1), .q1(d_q1),
        .PIOreq(d_PIOreq), .PIOwe(d_PIOwe), .PIOa(d_PIOa), .PIOd(d_PIOd),
        .PIOack(PIOack), .PIOq(PIOq), .busy(d_busy), .owner(d_owner)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk1({tag, "_PIOreq"}, PIOreq, 1'b0);
        chk1({tag, "_PIOwe"},  PIOwe,  1'b0);
        chk4({tag, "_PIOa"},   PIOa,   4'h0);
        chk16({tag, "_PIOd"},  PIOd,   16'h0000);
        chk1({tag, "_busy"},   busy,   1'b0);
        chk1({tag, "_owner"},  owner,  1'b0);
        chk1({tag, "_ack0"},   ack0,   1'b0);
        chk1({tag, "_ack1"},   ack1,   1'b0);
        chk1({tag, "_err0"},   err0,   1'b0);
        chk1({tag, "_err1"},   err1,   1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_signal = 1'b0; rst = 1'b0;
        req0 = 1'b0; we0 = 1'b0; adr0 = 4'h0; dat0 = 16'h0; lock0 = 1'b0;
        req1 = 1'b0; we1 = 1'b0; adr1 = 4'h0; dat1 = 16'h0; lock1 = 1'b0;
        PIOack = 1'b0; PIOq = 16'h0;
        step(); step(); #2;
        chk_reset("reset");
        chk1("reset_def_PIOreq", d_PIOreq, 1'b0);
        arst_signal = 1'b1;
        step();

        // T1: write to address 2, acked 20 cycles into BUSY (default watchdog)
        req0 = 1'b1; we0 = 1'b1; adr0 = 4'h2; dat0 = 16'h00A5; #2;
        chk1("t1_req_latency", d_PIOreq, 1'b0);
        step(); #2;
        chk1("t1_PIOreq", d_PIOreq, 1'b1);
        chk4("t1_PIOa", d_PIOa, 4'h2);
        chk16("t1_PIOd", d_PIOd, 16'h00A5);
        chk1("t1_PIOwe", d_PIOwe, 1'b1);
        chk1("t1_owner", d_owner, 1'b0);
        for (int c = 2; c <= 20; c++) begin
            step(); #2;
            chk1("t1_no_early_ack", d_ack0, 1'b0);
        end
        PIOack = 1'b1; PIOq = 16'h1234; #1;
        chk1("t1_ack0", d_ack0, 1'b1);
        chk1("t1_ack1", d_ack1, 1'b0);
        chk1("t1_err0", d_err0, 1'b0);
        chk1("t1_err1", d_err1, 1'b0);
        chk16("t1_q0", d_q0, 16'h1234);
        chk16("t1_q1", d_q1, 16'h1234);
        step(); PIOack = 1'b0; req0 = 1'b0; we0 = 1'b0; #2;
        chk1("t1_done_PIOreq", d_PIOreq, 1'b0);
        chk1("t1_done_ack0", d_ack0, 1'b0);
        chk1("t1_done_busy", d_busy, 1'b1);
        arst_signal = 1'b0;
        step(); #2;
        chk_reset("t1_rst");
        chk1("t1_rst_def_busy", d_busy, 1'b0);
        arst_signal = 1'b1;
        step();

        // T2: both requesting continuously -> 0,1,0,1
        req0 = 1'b1; adr0 = 4'h1; req1 = 1'b1; adr1 = 4'h5; #2;
        for (int i = 0; i < 4; i++) begin
            logic g;
            g = 1'(i % 2);
            step(); #2;
            chk1("t2_PIOreq", PIOreq, 1'b1);
            chk1("t2_owner", owner, g);
            chk4("t2_PIOa", PIOa, g ? 4'h5 : 4'h1);
            PIOack = 1'b1; PIOq = 16'h0F00 + 16'(i); #1;
            chk1("t2_ack0", ack0, ~g);
            chk1("t2_ack1", ack1, g);
            chk16("t2_q0", q0, 16'h0F00 + 16'(i));
            step(); PIOack = 1'b0; #2;
            chk1("t2_done_PIOreq", PIOreq, 1'b0);
            chk1("t2_done_busy", busy, 1'b1);
            step(); #2;
            chk1("t2_idle_busy", busy, 1'b0);
        end
        req0 = 1'b0; req1 = 1'b0;

        // T3: port 1 locks for three reads while port 0 waits
        step(); req1 = 1'b1; lock1 = 1'b1; we1 = 1'b0; adr1 = 4'h7; #2;
        step(); req0 = 1'b1; we0 = 1'b1; adr0 = 4'h3; dat0 = 16'hBEEF; #2;
        for (int k = 0; k < 3; k++) begin
            chk1("t3_PIOreq", PIOreq, 1'b1);
            chk1("t3_owner", owner, 1'b1);
            chk4("t3_PIOa", PIOa, 4'h7);
            chk1("t3_PIOwe", PIOwe, 1'b0);
            PIOack = 1'b1; PIOq = 16'hC000 + 16'(k); #1;
            chk1("t3_ack1", ack1, 1'b1);
            chk1("t3_ack0", ack0, 1'b0);
            chk16("t3_q1", q1, 16'hC000 + 16'(k));
            step(); PIOack = 1'b0; #2;
            chk1("t3_done_PIOreq", PIOreq, 1'b0);
            step(); #2;
            chk1("t3_lock_PIOreq", PIOreq, 1'b0);
            chk1("t3_lock_busy", busy, 1'b1);
            chk1("t3_lock_ack0", ack0, 1'b0);
            if (k == 2) begin
                lock1 = 1'b0; req1 = 1'b0;
            end
            step(); #2;
        end
        chk1("t3_released_busy", busy, 1'b0);
        step(); #2;
        chk1("t3_port0_owner", owner, 1'b0);
        chk4("t3_port0_PIOa", PIOa, 4'h3);
        chk16("t3_port0_PIOd", PIOd, 16'hBEEF);
        chk1("t3_port0_PIOwe", PIOwe, 1'b1);
        PIOack = 1'b1; #1;
        chk1("t3_port0_ack0", ack0, 1'b1);
        step(); PIOack = 1'b0; req0 = 1'b0; we0 = 1'b0; #2;
        step(); #2;

        // T4: watchdog fires on the 16th BUSY cycle; a late PIOack is ignored
        req0 = 1'b1; adr0 = 4'h4; #2;
        step(); #2;
        for (int c = 1; c <= 16; c++) begin
            chk1("t4_err0", err0, (c == 16));
            if (c < 16) begin
                step(); #2;
            end
        end
        chk1("t4_ack0", ack0, 1'b0);
        chk1("t4_err1", err1, 1'b0);
        chk1("t4_PIOreq_last", PIOreq, 1'b1);
        step(); req0 = 1'b0; #2;
        chk1("t4_done_PIOreq", PIOreq, 1'b0);
        chk1("t4_done_err0", err0, 1'b0);
        step(); PIOack = 1'b1; #1;
        chk1("t4_late_ack0", ack0, 1'b0);
        chk1("t4_late_ack1", ack1, 1'b0);
        step(); PIOack = 1'b0; #2;
        chk1("t4_idle_busy", busy, 1'b0);

        // T5: PIOack coinciding with the timeout gives ack only
        req1 = 1'b1; adr1 = 4'h6; #2;
        step(); #2;
        for (int c = 2; c <= 16; c++) begin
            step(); #2;
        end
        PIOack = 1'b1; #1;
        chk1("t5_ack1", ack1, 1'b1);
        chk1("t5_err1", err1, 1'b0);
        chk1("t5_err0", err0, 1'b0);
        step(); PIOack = 1'b0; req1 = 1'b0; #2;
        step(); #2;

        // T6: async reset mid-BUSY, sync reset in LOCK, forced lock release
        req0 = 1'b1; we0 = 1'b1; adr0 = 4'h9; dat0 = 16'h5555; #2;
        step(); #2;
        chk1("t6_busy_PIOreq", PIOreq, 1'b1);
        arst_signal = 1'b0;
        step(); #2;
        chk_reset("t6_arst");
        arst_signal = 1'b1; req0 = 1'b0; we0 = 1'b0;
        req1 = 1'b1; lock1 = 1'b1; adr1 = 4'hA; #2;
        step(); #2;
        chk1("t6_req1_owner", owner, 1'b1);
        chk1("t6_req1_PIOreq", PIOreq, 1'b1);
        PIOack = 1'b1; #1;
        chk1("t6_req1_ack1", ack1, 1'b1);
        step(); PIOack = 1'b0; req1 = 1'b0; #2;
        step(); #2;
        chk1("t6_lock_busy", busy, 1'b1);
        chk1("t6_lock_PIOreq", PIOreq, 1'b0);
        rst = 1'b1;
        step(); #2;
        chk_reset("t6_srst");
        rst = 1'b0; req1 = 1'b1;
        step(); PIOack = 1'b1; #1;
        chk1("t6_relock_ack1", ack1, 1'b1);
        step(); PIOack = 1'b0; req1 = 1'b0; #2;
        step(); req0 = 1'b1; adr0 = 4'h1; #2;
        for (int c = 1; c <= 8; c++) begin
            chk1("t6_lock_hold_busy", busy, 1'b1);
            chk1("t6_lock_hold_PIOreq", PIOreq, 1'b0);
            chk1("t6_lock_hold_ack0", ack0, 1'b0);
            step(); #2;
        end
        chk1("t6_forced_release", busy, 1'b0);
        step(); #2;
        chk1("t6_port0_owner", owner, 1'b0);
        chk1("t6_port0_PIOreq", PIOreq, 1'b1);
        PIOack = 1'b1; #1;
        chk1("t6_port0_ack0", ack0, 1'b1);
        step(); PIOack = 1'b0; req0 = 1'b0; #2;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
